// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the I2S capture path.
// Stereo pair struct, receiver state encoding, I2S framing constants.
package audio_pkg;

  localparam int AUDIO_DATA_W   = 16;
  localparam int I2S_DELAY_BITS = 1;

  typedef struct packed {
    logic [AUDIO_DATA_W-1:0] left;
    logic [AUDIO_DATA_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_if.sv
// i2s_rx_if: stereo sample output bundle of the I2S receiver.
// master: pair, valid, overrun (+ peaks with I2S_RX_PEAK_EN); slave: ready, clear.
interface i2s_rx_if
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W
);

  logic [DATA_W-1:0] sample_left;
  logic [DATA_W-1:0] sample_right;
  logic              sample_valid;
  logic              sample_ready;
  logic              overrun;
  logic              clear_overrun;
`ifdef I2S_RX_PEAK_EN
  logic [DATA_W-2:0] peak_left;
  logic [DATA_W-2:0] peak_right;
`endif

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    output overrun,
`ifdef I2S_RX_PEAK_EN
    output peak_left,
    output peak_right,
`endif
    input  sample_ready,
    input  clear_overrun
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    input  overrun,
`ifdef I2S_RX_PEAK_EN
    input  peak_left,
    input  peak_right,
`endif
    output sample_ready,
    output clear_overrun
  );

endinterface

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: STAGES-deep synchroniser with rising-edge pulse per bit.
// Ports: clk_i, rst_i (async high), async_i -> sync_o level, rise_o pulse.
module i2s_sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S capture receiver, one stereo pair per frame on a handshake.
// Ports: MCLK, reset, enable, sclk_in/lrclk_in/sdata_in (async), rx (master).
// Option I2S_RX_PEAK_EN: adds peak_left/peak_right running |sample| maxima.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int DATA_W      = AUDIO_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic     MCLK,
  input  logic     reset,
  input  logic     enable,
  input  logic     sclk_in,
  input  logic     lrclk_in,
  input  logic     sdata_in,
  i2s_rx_if.master rx
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int IW = $clog2(DATA_W);

  localparam logic [1:0] ST_SYNC  = SYNC;
  localparam logic [1:0] ST_LEFT  = LEFT;
  localparam logic [1:0] ST_RIGHT = RIGHT;

  logic       tick;
  logic       lr_s;
  logic       sd_s;
  logic       sclk_lvl_unused;
  logic [1:0] lrsd_s;
  logic [1:0] lrsd_rise_unused;

  // lr/sd share the sclk depth so they are sampled aligned with the tick
  i2s_sync_edge #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_sclk (
    .clk_i   (MCLK),
    .rst_i   (reset),
    .async_i (sclk_in),
    .sync_o  (sclk_lvl_unused),
    .rise_o  (tick)
  );

  i2s_sync_edge #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (2)
  ) u_lrsd (
    .clk_i   (MCLK),
    .rst_i   (reset),
    .async_i ({sdata_in, lrclk_in}),
    .sync_o  (lrsd_s),
    .rise_o  (lrsd_rise_unused)
  );

  assign lr_s = lrsd_s[0];
  assign sd_s = lrsd_s[1];

  logic [1:0]        state_q, state_d;
  logic              lr_prev_q, lr_prev_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] left_q, left_d;
  stereo_sample_t    pair_q, pair_d;
  stereo_sample_t    new_pair;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              pair_done;
  logic              slot_free;
  logic              load;
  logic [IW-1:0]     bit_idx;

  // Word assembly: bits land directly at their MSB-first position,
  // so short words come out left-justified with zero LSBs.
  always_comb begin
    state_d   = state_q;
    lr_prev_d = lr_prev_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    pair_done = 1'b0;
    new_pair  = '{left: left_q, right: shift_q};
    bit_idx   = IW'(DATA_W - 1) - cnt_q[IW-1:0];
    if (tick) begin
      lr_prev_d = lr_s;
      if (lr_s != lr_prev_q) begin
        // delay bit: close the word that just ended
        shift_d = '0;
        cnt_d   = CW'(I2S_DELAY_BITS - 1);
        unique case (state_q)
          ST_SYNC: begin
            if (!lr_s) state_d = ST_LEFT;
          end
          ST_LEFT: begin
            if (lr_s) begin
              left_d  = shift_q;
              state_d = ST_RIGHT;
            end
          end
          ST_RIGHT: begin
            if (!lr_s) begin
              pair_done = 1'b1;
              state_d   = ST_LEFT;
            end
          end
          default: state_d = ST_SYNC;
        endcase
      end else if (cnt_q < CW'(DATA_W)) begin
        shift_d[bit_idx] = sd_s;
        cnt_d            = cnt_q + CW'(1);
      end
    end
    if (!enable) begin
      state_d   = ST_SYNC;
      shift_d   = '0;
      cnt_d     = '0;
      pair_done = 1'b0;
    end
  end

  assign slot_free = !valid_q || rx.sample_ready;
  assign load      = pair_done && slot_free;

  always_comb begin
    pair_d  = pair_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && rx.sample_ready) valid_d = 1'b0;
    if (load) begin
      pair_d  = new_pair;
      valid_d = 1'b1;
    end
    if (rx.clear_overrun) ovr_d = 1'b0;
    // a drop in the clear cycle still flags
    if (pair_done && !slot_free) ovr_d = 1'b1;
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SYNC;
      lr_prev_q <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      left_q    <= '0;
      pair_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lr_prev_q <= lr_prev_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      pair_q    <= pair_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx.sample_left  = pair_q.left;
  assign rx.sample_right = pair_q.right;
  assign rx.sample_valid = valid_q;
  assign rx.overrun      = ovr_q;

`ifdef I2S_RX_PEAK_EN
  // |s| with the most negative code clamped to max positive
  function automatic logic [DATA_W-2:0] mag(
    input logic [DATA_W-1:0] s
  );
    logic [DATA_W-1:0] n;
    n = -s;
    if (!s[DATA_W-1]) return s[DATA_W-2:0];
    if (s[DATA_W-2:0] == '0) return '1;
    return n[DATA_W-2:0];
  endfunction

  logic [DATA_W-2:0] pk_l_q, pk_l_d;
  logic [DATA_W-2:0] pk_r_q, pk_r_d;
  logic [DATA_W-2:0] mag_l, mag_r;
  logic [DATA_W-2:0] base_l, base_r;

  always_comb begin
    mag_l  = mag(new_pair.left);
    mag_r  = mag(new_pair.right);
    base_l = rx.clear_overrun ? '0 : pk_l_q;
    base_r = rx.clear_overrun ? '0 : pk_r_q;
    pk_l_d = base_l;
    pk_r_d = base_r;
    if (load && mag_l > base_l) pk_l_d = mag_l;
    if (load && mag_r > base_r) pk_r_d = mag_r;
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      pk_l_q <= '0;
      pk_r_q <= '0;
    end else begin
      pk_l_q <= pk_l_d;
      pk_r_q <= pk_r_d;
    end
  end

  assign rx.peak_left  = pk_l_q;
  assign rx.peak_right = pk_r_q;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed frame bench for i2s_rx.
// Drives I2S frames at MCLK/8 and checks delivered pairs and flags.
module tb_i2s_rx;

  logic MCLK = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic sclk_in = 1'b1;
  logic lrclk_in = 1'b1;
  logic sdata_in = 1'b0;

  i2s_rx_if #(.DATA_W(16)) bus();

  i2s_rx #(
    .DATA_W      (16),
    .SYNC_STAGES (2)
  ) dut (
    .MCLK     (MCLK),
    .reset    (reset),
    .enable   (enable),
    .sclk_in  (sclk_in),
    .lrclk_in (lrclk_in),
    .sdata_in (sdata_in),
    .rx       (bus)
  );

  always #10 MCLK = ~MCLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // handshake and latency monitors
  int          cyc = 0;
  int          rise_cyc = 0;
  int          lat_last = -1;
  int          acc_cnt = 0;
  logic [15:0] acc_l = '0;
  logic [15:0] acc_r = '0;
  logic        v_prev = 1'b0;

  always @(posedge MCLK) cyc = cyc + 1;
  always @(posedge sclk_in) rise_cyc = cyc;

  always @(negedge MCLK) begin
    if (bus.sample_valid && !v_prev) lat_last = cyc - rise_cyc;
    v_prev = bus.sample_valid;
    if (bus.sample_valid && bus.sample_ready) begin
      acc_cnt = acc_cnt + 1;
      acc_l   = bus.sample_left;
      acc_r   = bus.sample_right;
    end
  end

  task automatic send_bit(input logic lr, input logic sd);
    repeat (4) @(posedge MCLK);
    #5;
    sclk_in  = 1'b0;
    lrclk_in = lr;
    sdata_in = sd;
    repeat (4) @(posedge MCLK);
    #5;
    sclk_in = 1'b1;
  endtask

  task automatic send_n(input logic lr, input int n);
    for (int i = 0; i < n; i++) send_bit(lr, 1'b1);
  endtask

  // lead-in with lr high, then the first left delay bit
  task automatic start(input int n);
    send_n(1'b1, n);
    send_bit(1'b0, 1'b1);
  endtask

  // left data+pad, right slot, then the next left delay bit
  task automatic frame(
    input logic [15:0] l,
    input logic [15:0] r,
    input int          nb = 16,
    input int          len = 32
  );
    for (int i = nb - 1; i >= 0; i--) send_bit(1'b0, l[i]);
    for (int i = nb + 1; i < len; i++) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    for (int i = nb - 1; i >= 0; i--) send_bit(1'b1, r[i]);
    for (int i = nb + 1; i < len; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    repeat (6) @(posedge MCLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge MCLK);
    #3 reset = 1'b1;
    repeat (2) @(posedge MCLK);
    #3 reset = 1'b0;
    #1;
  endtask

  task automatic pulse_clear();
    @(posedge MCLK);
    #5 bus.clear_overrun = 1'b1;
    @(posedge MCLK);
    #5 bus.clear_overrun = 1'b0;
    @(posedge MCLK);
    #1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge MCLK);
    #5 bus.sample_ready = v;
    repeat (2) @(posedge MCLK);
    #1;
  endtask

  int base;

  initial begin
    bus.sample_ready  = 1'b1;
    bus.clear_overrun = 1'b0;
    repeat (3) @(posedge MCLK);
    #3 reset = 1'b0;
    #1;
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_left", bus.sample_left, 0);
    chk("rst_right", bus.sample_right, 0);
    chk("rst_ovr", bus.overrun, 0);

    // normal 64fs frames, ready high
    start(3);
    chk("t1_none", acc_cnt, 0);
    frame(16'h1234, 16'hABCD);
    chk("t1_cnt", acc_cnt, 1);
    chk("t1_l", acc_l, 16'h1234);
    chk("t1_r", acc_r, 16'hABCD);
    chk("t1_lat", lat_last, 3);
    chk("t1_vlow", bus.sample_valid, 0);
    frame(16'h8001, 16'h7FFE);
    chk("t1b_cnt", acc_cnt, 2);
    chk("t1b_l", acc_l, 16'h8001);
    chk("t1b_r", acc_r, 16'h7FFE);
    chk("t1b_lat", lat_last, 3);

    // backpressure and overrun
    set_ready(1'b0);
    base = acc_cnt;
    frame(16'h1111, 16'hAAAA);
    chk("t2_ovr0", bus.overrun, 0);
    frame(16'h2222, 16'hBBBB);
    frame(16'h3333, 16'hCCCC);
    chk("t2_valid", bus.sample_valid, 1);
    chk("t2_l", bus.sample_left, 16'h1111);
    chk("t2_r", bus.sample_right, 16'hAAAA);
    chk("t2_ovr", bus.overrun, 1);
    chk("t2_cnt", acc_cnt, base);
    set_ready(1'b1);
    chk("t2_acc", acc_cnt, base + 1);
    chk("t2_accl", acc_l, 16'h1111);
    frame(16'h4444, 16'hDDDD);
    chk("t2_nxt_cnt", acc_cnt, base + 2);
    chk("t2_nxt_l", acc_l, 16'h4444);
    chk("t2_nxt_r", acc_r, 16'hDDDD);
    chk("t2_ovr_stk", bus.overrun, 1);
    pulse_clear();
    chk("t2_ovr_clr", bus.overrun, 0);

    // stream picked up mid right word
    do_reset();
    base = acc_cnt;
    start(7);
    chk("t3_none", acc_cnt, base);
    frame(16'h5A5A, 16'hC3C3);
    chk("t3_cnt", acc_cnt, base + 1);
    chk("t3_l", acc_l, 16'h5A5A);
    chk("t3_r", acc_r, 16'hC3C3);

    // short 12-bit words are left-justified
    frame(16'h0ABC, 16'h0123, 12, 13);
    chk("t4_cnt", acc_cnt, base + 2);
    chk("t4_l", acc_l, 16'hABC0);
    chk("t4_r", acc_r, 16'h1230);

    // reset in the middle of a left word
    send_n(1'b0, 5);
    do_reset();
    chk("t5_valid", bus.sample_valid, 0);
    chk("t5_l", bus.sample_left, 0);
    chk("t5_r", bus.sample_right, 0);
    chk("t5_ovr", bus.overrun, 0);
    base = acc_cnt;
    send_n(1'b0, 26);
    send_n(1'b1, 32);
    send_bit(1'b0, 1'b1);
    repeat (6) @(posedge MCLK);
    #1;
    chk("t5_none", acc_cnt, base);
    frame(16'h0F0F, 16'hF0F0);
    chk("t5_cnt", acc_cnt, base + 1);
    chk("t5_pl", acc_l, 16'h0F0F);
    chk("t5_pr", acc_r, 16'hF0F0);

    // enable dropped for one frame
    base = acc_cnt;
    send_n(1'b0, 5);
    @(posedge MCLK);
    #5 enable = 1'b0;
    send_n(1'b0, 26);
    send_n(1'b1, 32);
    send_bit(1'b0, 1'b1);
    repeat (6) @(posedge MCLK);
    #1;
    chk("t6_none", acc_cnt, base);
    chk("t6_hold", bus.sample_left, 16'h0F0F);
    @(posedge MCLK);
    #5 enable = 1'b1;
    frame(16'h1357, 16'h2468);
    chk("t6_resync", acc_cnt, base);
    frame(16'h1357, 16'h2468);
    chk("t6_cnt", acc_cnt, base + 1);
    chk("t6_l", acc_l, 16'h1357);
    chk("t6_r", acc_r, 16'h2468);
    chk("t6_lat", lat_last, 3);

`ifdef I2S_RX_PEAK_EN
    pulse_clear();
    chk("pk_clr", bus.peak_left, 0);
    frame(16'h0100, 16'hFF00);
    frame(16'h8000, 16'h0005);
    chk("pk_l", bus.peak_left, 15'h7FFF);
    chk("pk_r", bus.peak_right, 15'h0100);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Receives the SGTL5000 ADC serial stream (codec DOUT on ARDUINO_IO[1]) in I2S format.
- This is the capture direction; the existing audio interface generates the clocks and drives codec DIN.
- sclk_in, lrclk_in and sdata_in are asynchronous. They are synchronised into the 50 MHz system clock.
- Output is one stereo sample pair per frame through a valid/ready handshake, for the NES audio mixer and the SoC.

Parameters:
- DATA_W, 16, bits kept per channel word; MSB-first, extra slot bits discarded.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input.

Ports:
- MCLK  in  1  50 MHz system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  0: force SYNC state, drop partial words.
- sclk_in  in  1  I2S bit clock from the audio interface; async.
- lrclk_in  in  1  I2S word select; 0 = left, 1 = right; async.
- sdata_in  in  1  codec serial data; async.
- sample_left  out  DATA_W  left word of the held pair.
- sample_right  out  DATA_W  right word of the held pair.
- sample_valid  out  1  held pair is valid.
- sample_ready  in  1  consumer accepts the pair when valid && ready.
- overrun  out  1  sticky: a completed pair was dropped.
- clear_overrun  in  1  synchronous clear of overrun.

Behaviour:
Reset and input timing:
- Reset values: all outputs 0, state SYNC, bit counter 0.
- Reset asserted mid-frame aborts the frame; no partial pair is emitted.
- Requirement on the source: sclk_in ≤ MCLK/8 (nominal 3.072 MHz = 64·fs at 48 kHz).

Bit-clock tick:
- Each asynchronous input passes through SYNC_STAGES flops.
- A tick is a one-cycle pulse on the synchronised rising edge of SCLK.
- lr and sd are sampled on that same tick. lr_prev holds lr from the previous tick.

Word assembly (per tick):
- lr != lr_prev: this is the I2S delay bit. Its data is ignored. The current shift register is finalised as the word that just ended, and bit_cnt is set to 0.
- lr == lr_prev and bit_cnt < DATA_W: shift sd into the word MSB-first and increment bit_cnt.
- lr == lr_prev and bit_cnt ≥ DATA_W: the bit is ignored and bit_cnt saturates.
- A word shorter than DATA_W is finalised left-justified with zero LSBs. Example: 12 bits received as 0xABC becomes 0xABC0.

States:
- SYNC: wait for the first lr 1→0 tick (start of a left word), then go to LEFT. Nothing is finalised in SYNC.
- LEFT: on lr 0→1, latch the left word into left_hold and go to RIGHT.
- RIGHT: on lr 1→0, the pair {left_hold, word} is complete. Go to LEFT, since this edge is also the delay bit of the next left word.
- enable = 0 in any state returns to SYNC on the next cycle. sample_valid, held data and overrun are unaffected.

Output handshake:
- A completed pair is written to the output registers in the cycle after the finishing tick, if the register slot is free.
- The slot is free when !sample_valid, or when sample_valid && sample_ready in that same cycle (simultaneous accept and new pair: the new pair is loaded and valid stays 1).
- The held pair stays stable while valid && !ready.
- A pair arriving with the slot occupied and not being accepted is dropped, and overrun is set.
- clear_overrun clears the flag. If a drop happens in the same cycle as clear_overrun, set wins.
- Latency: the last sd bit of the right word is captured at the tick that carries the lr 1→0 transition. sample_valid rises exactly 1 MCLK after that tick pulse.

Optional Feature:
- Macro I2S_RX_PEAK_EN.
- When defined, adds two outputs: peak_left and peak_right, each DATA_W-1 bits.
- Each holds the running maximum of |sample| of delivered pairs, in two's-complement. -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
- The peaks are cleared by reset or by clear_overrun. They are updated on the cycle the pair is loaded into the output registers.
- Intended for HEX display.
- When undefined, these ports and their logic do not exist.

Decomposition:
- Package audio_pkg holds:
  - typedef stereo_sample_t (struct of left and right words, DATA_W each);
  - enum i2s_rx_state_t {SYNC, LEFT, RIGHT};
  - localparam I2S_DELAY_BITS = 1.
- Sub-module i2s_sync_edge: parameterised synchroniser plus rising-edge pulse generator. One instance for sclk_in; lrclk_in and sdata_in use synchroniser only, with matched depth.

Test Plan:
- 64·fs frames, left 0x1234 and right 0xABCD, ready held at 1 → one valid pulse per frame with exactly those values, 1 MCLK after the right-word end tick.
- ready = 0 across three frames with lefts 0x1111, 0x2222, 0x3333 → output holds 0x1111 and overrun = 1. Then ready = 1 → next frame delivered; clear_overrun → overrun = 0.
- Stream started mid-right-word → no valid until after the first complete left+right frame; first pair exact.
- 12-bit slots sending 0xABC and 0x123 → left 0xABC0, right 0x1230.
- Reset pulsed mid-left word → outputs 0 and state SYNC; first pair after reset is taken only from a full subsequent frame. Same check for enable dropped for one frame.
- With I2S_RX_PEAK_EN: pairs (0x0100, 0xFF00), then (0x8000, 0x0005) → peak_left = 0x7FFF, peak_right = 0x0100.
